// File: rtl/emergency_preempt_arbiter_pkg.sv
// Shared codes for the emergency preemption arbiter and the traffic light controller it drives.
// Pure definitions; no logic, no timing.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_GRANT   = 2'd2,
        ST_HOLDOFF = 2'd3
    } arb_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam logic [1:0] LIGHT_G = 2'b00;
    localparam logic [1:0] LIGHT_Y = 2'b01;
    localparam logic [1:0] LIGHT_R = 2'b10;

endpackage

// File: rtl/emergency_preempt_arbiter_if.sv
// Request/route inputs and light-controller outputs of the preemption arbiter.
// The master side (detectors) drives requests; the slave side (arbiter) drives the rest.
interface emergency_preempt_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] req_dir;
    logic             emergency_left;
    logic             emergency_right;
    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    grant_id;
    logic             busy;
    logic             done;

    modport master (
        output req, req_dir,
        input  emergency_left, emergency_right, grant, grant_id, busy, done
    );

    modport slave (
        input  req, req_dir,
        output emergency_left, emergency_right, grant, grant_id, busy, done
    );
endinterface

// File: rtl/emergency_preempt_arbiter_req_debounce.sv
// Single-channel request debouncer: valid after DEB_TICKS consecutive high samples,
// drops on the first low sample. No backpressure.
module req_debounce #(
    parameter int DEB_TICKS = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic valid
);
    localparam int DW = $clog2(DEB_TICKS + 1);
    localparam logic [DW-1:0] LAST = DW'(DEB_TICKS - 1);

    logic [DW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            valid <= 1'b0;
        end else if (!raw) begin
            cnt   <= '0;
            valid <= 1'b0;
        end else if (!valid) begin
            if (cnt == LAST) begin
                valid <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/emergency_preempt_arbiter.sv
// Round-robin emergency preemption arbiter: debounce -> all-red clearance -> bounded grant -> hold-off.
// Outputs registered from next state (no extra lag); requests are level, no backpressure.
module emergency_preempt_arbiter
    import traffic_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int DEB_TICKS     = 2,
    parameter int CLR_TICKS     = 3,
    parameter int GRANT_TICKS   = 10,
    parameter int HOLDOFF_TICKS = 5,
    parameter int CW            = 7
) (
    input logic clk,
    input logic reset,
    emergency_preempt_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_TICKS - 1);
    localparam logic [CW-1:0] GRANT_LAST = CW'(GRANT_TICKS - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLDOFF_TICKS - 1);

    logic [N_REQ-1:0] valid;

    for (genvar g = 0; g < N_REQ; g++) begin : g_deb
        req_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb (
            .clk   (clk),
            .reset (reset),
            .raw   (bus.req[g]),
            .valid (valid[g])
        );
    end

    arb_state_t       state_q, state_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [IW-1:0]    winner_q, winner_n;
    logic [IW-1:0]    rr_q, rr_n;
    logic             dir_q, dir_n;

    logic             left_q, left_n;
    logic             right_q, right_n;
    logic [N_REQ-1:0] grant_q, grant_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;

    logic             pick_vld;
    logic [IW-1:0]    pick_idx;

    // First valid requester at or after the rr pointer, wrapping.
    always_comb begin
        int j;
        j        = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(rr_q) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!pick_vld && valid[j]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(j);
            end
        end
    end

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        winner_n = winner_q;
        rr_n     = rr_q;
        dir_n    = dir_q;
        done_n   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_n  = ST_CLEAR;
                    winner_n = pick_idx;
                    dir_n    = bus.req_dir[pick_idx];
                end
            end
            ST_CLEAR: begin
                if (cnt_q == CLR_LAST) begin
                    state_n = ST_GRANT;
                    rr_n    = (winner_q == IW'(N_REQ - 1)) ? '0 : winner_q + 1'b1;
                end
            end
            ST_GRANT: begin
                if (cnt_q == GRANT_LAST || !bus.req[winner_q]) begin
                    state_n = ST_HOLDOFF;
                    done_n  = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == HOLD_LAST) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        // Every phase exits at TICKS-1, so the counter can never wrap.
        if (state_n != state_q)      cnt_n = '0;
        else if (state_q != ST_IDLE) cnt_n = cnt_q + 1'b1;

        grant_n = '0;
        if (state_n == ST_GRANT) grant_n[winner_n] = 1'b1;
        left_n  = (state_n == ST_GRANT) && (dir_n == DIR_LEFT);
        right_n = (state_n == ST_CLEAR) || ((state_n == ST_GRANT) && (dir_n == DIR_RIGHT));
        busy_n  = (state_n != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            winner_q <= '0;
            rr_q     <= '0;
            dir_q    <= 1'b0;
            left_q   <= 1'b0;
            right_q  <= 1'b0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            winner_q <= winner_n;
            rr_q     <= rr_n;
            dir_q    <= dir_n;
            left_q   <= left_n;
            right_q  <= right_n;
            grant_q  <= grant_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
        end
    end

    assign bus.emergency_left  = left_q;
    assign bus.emergency_right = right_q;
    assign bus.grant           = grant_q;
    assign bus.grant_id        = winner_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
endmodule

// File: tb/tb_emergency_preempt_arbiter.sv
// Directed table-driven bench for emergency_preempt_arbiter with default parameters.
module tb_emergency_preempt_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    emergency_preempt_arbiter_if #(.N_REQ(4)) bus ();

    emergency_preempt_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] dir;
        int         n;
        logic       l;
        logic       r;
        logic [3:0] g;
        logic [1:0] id;
        logic       b;
        logic       d;
    } vec_t;

    vec_t vq[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void add(logic [3:0] req, logic [3:0] dir, int n, logic l, logic r,
                                logic [3:0] g, logic [1:0] id, logic b, logic d);
        vec_t v;
        v.req = req; v.dir = dir; v.n = n; v.l = l; v.r = r;
        v.g = g; v.id = id; v.b = b; v.d = d;
        vq.push_back(v);
    endfunction

    // Packed view: {left, right, grant[3:0], grant_id[1:0], busy, done}
    task automatic check(string name, logic [9:0] exp);
        logic [9:0] act;
        act = {bus.emergency_left, bus.emergency_right, bus.grant, bus.grant_id, bus.busy, bus.done};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got l=%b r=%b g=%b id=%0d busy=%b done=%b, expected l=%b r=%b g=%b id=%0d busy=%b done=%b",
                     name, act[9], act[8], act[7:4], act[3:2], act[1], act[0],
                     exp[9], exp[8], exp[7:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    task automatic run_table(string tname);
        for (int k = 0; k < vq.size(); k++) begin
            for (int c = 0; c < vq[k].n; c++) begin
                bus.req     = vq[k].req;
                bus.req_dir = vq[k].dir;
                @(posedge clk);
                #1;
                check($sformatf("%s row%0d cyc%0d", tname, k, c),
                      {vq[k].l, vq[k].r, vq[k].g, vq[k].id, vq[k].b, vq[k].d});
            end
        end
        vq.delete();
    endtask

    task automatic do_reset(string tname);
        bus.req     = '0;
        bus.req_dir = '0;
        reset = 1'b1;
        #1;
        check({tname, " reset"}, 10'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.req     = '0;
        bus.req_dir = '0;
        do_reset("init");

        // Single requester held, left route: full cycle then a fresh CLEAR.
        add(4'b0001, 4'b0000, 2,  0, 0, 4'b0000, 2'd0, 0, 0);
        add(4'b0001, 4'b0000, 3,  0, 1, 4'b0000, 2'd0, 1, 0);
        add(4'b0001, 4'b0000, 10, 1, 0, 4'b0001, 2'd0, 1, 0);
        add(4'b0001, 4'b0000, 1,  0, 0, 4'b0000, 2'd0, 1, 1);
        add(4'b0001, 4'b0000, 4,  0, 0, 4'b0000, 2'd0, 1, 0);
        add(4'b0001, 4'b0000, 1,  0, 0, 4'b0000, 2'd0, 0, 0);
        add(4'b0001, 4'b0000, 1,  0, 1, 4'b0000, 2'd0, 1, 0);
        run_table("single");
        do_reset("single");

        // One-cycle glitch never becomes valid.
        add(4'b0010, 4'b0000, 1, 0, 0, 4'b0000, 2'd0, 0, 0);
        add(4'b0000, 4'b0000, 5, 0, 0, 4'b0000, 2'd0, 0, 0);
        run_table("glitch");
        do_reset("glitch");

        // All four held, right route: round-robin order wraps back to 0.
        add(4'b1111, 4'b1111, 2, 0, 0, 4'b0000, 2'd0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            add(4'b1111, 4'b1111, 3,  0, 1, 4'b0000, 2'(k % 4), 1, 0);
            add(4'b1111, 4'b1111, 10, 0, 1, 4'(1 << (k % 4)), 2'(k % 4), 1, 0);
            if (k < 4) begin
                add(4'b1111, 4'b1111, 1, 0, 0, 4'b0000, 2'(k % 4), 1, 1);
                add(4'b1111, 4'b1111, 4, 0, 0, 4'b0000, 2'(k % 4), 1, 0);
                add(4'b1111, 4'b1111, 1, 0, 0, 4'b0000, 2'(k % 4), 0, 0);
            end
        end
        run_table("rr");
        do_reset("rr");

        // Request drops during the 4th GRANT cycle: early exit.
        add(4'b0100, 4'b0000, 2, 0, 0, 4'b0000, 2'd0, 0, 0);
        add(4'b0100, 4'b0000, 3, 0, 1, 4'b0000, 2'd2, 1, 0);
        add(4'b0100, 4'b0000, 4, 1, 0, 4'b0100, 2'd2, 1, 0);
        add(4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 2'd2, 1, 1);
        add(4'b0000, 4'b0000, 4, 0, 0, 4'b0000, 2'd2, 1, 0);
        add(4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 2'd2, 0, 0);
        run_table("early");
        do_reset("early");

        // Route change mid-GRANT is ignored until exit.
        add(4'b1000, 4'b0000, 2, 0, 0, 4'b0000, 2'd0, 0, 0);
        add(4'b1000, 4'b0000, 3, 0, 1, 4'b0000, 2'd3, 1, 0);
        add(4'b1000, 4'b0000, 3, 1, 0, 4'b1000, 2'd3, 1, 0);
        add(4'b1000, 4'b1000, 7, 1, 0, 4'b1000, 2'd3, 1, 0);
        add(4'b1000, 4'b1000, 1, 0, 0, 4'b0000, 2'd3, 1, 1);
        run_table("dirflip");
        do_reset("dirflip");

        // Asynchronous reset in the middle of a grant, then re-debounce.
        add(4'b0001, 4'b0000, 2, 0, 0, 4'b0000, 2'd0, 0, 0);
        add(4'b0001, 4'b0000, 3, 0, 1, 4'b0000, 2'd0, 1, 0);
        add(4'b0001, 4'b0000, 2, 1, 0, 4'b0001, 2'd0, 1, 0);
        run_table("midgrant");
        reset = 1'b1;
        #1;
        check("midgrant async clear", 10'b0);
        @(negedge clk);
        reset = 1'b0;
        add(4'b0001, 4'b0000, 2, 0, 0, 4'b0000, 2'd0, 0, 0);
        add(4'b0001, 4'b0000, 1, 0, 1, 4'b0000, 2'd0, 1, 0);
        run_table("redebounce");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
